sysid_info_regs: RTL and testbench
==================================

SYSID_INFO_REGS -- requirements
Module: sysid_info_regs

Interface
REQ-001 Parameter SYSTEM_ID, default 32'h57FA_9A28, meaning constant returned at word 0.
REQ-002 Parameter TIMESTAMP, default 32'h0, meaning build timestamp returned at word 1.
REQ-003 Parameter UPTIME_W, default 48, legal 33..64, meaning uptime counter width.
REQ-004 Parameter NUM_SCRATCH, default 2, legal 1..8, meaning number of 32-bit scratch registers.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 address  input  4  word address.
REQ-008 read  input  1  read strobe, one cycle per access.
REQ-009 write  input  1  write strobe, one cycle per access.
REQ-010 writedata  input  32  write data.
REQ-011 byteenable  input  4  byte lanes for writes.
REQ-012 readdata  output  32  registered read data.
REQ-013 readdatavalid  output  1  high exactly one cycle, qualifying readdata.

Function
REQ-014 Word map SHALL be: 0 SYSTEM_ID (RO), 1 TIMESTAMP (RO), 2 UPTIME_LO (RO), 3 UPTIME_HI snapshot (RO), 4 CONTROL (RW), 5..4+NUM_SCRATCH scratch (RW); all other addresses read 0, writes ignored.
REQ-015 Read latency SHALL be fixed 1: read sampled at edge N -> readdata/readdatavalid valid after edge N+1 only; no waitrequest.
REQ-016 readdata SHALL hold its last value when readdatavalid is low.
REQ-017 Uptime counter SHALL increment by 1 every cycle when CONTROL.freeze=0, wrapping from 2^UPTIME_W-1 to 0.
REQ-018 Reading word 2 SHALL return counter bits [31:0] and, on the same edge, latch bits [UPTIME_W-1:32] (zero-extended) into the HI snapshot.
REQ-019 Reading word 3 SHALL return the snapshot, not the live counter; snapshot changes only on a word-2 read or reset.
REQ-020 CONTROL bit0 clear: writing 1 SHALL zero the counter on that edge; bit reads 0 always (self-clearing).
REQ-021 CONTROL bit1 freeze: RW, holds the counter while 1; bits [31:2] read 0.
REQ-022 Clear and freeze written together SHALL zero the counter and hold it at 0.
REQ-023 Counter value read on the same edge as a clear write SHALL be the pre-clear value.
REQ-024 Scratch and CONTROL writes SHALL honour byteenable per lane; byteenable=0 writes nothing.
REQ-025 read and write asserted together SHALL service the read and ignore the write.
REQ-026 Scratch read in the cycle after a write SHALL return the written value.

Reset
REQ-027 reset_n low at an edge SHALL set readdata=0, readdatavalid=0, counter=0, snapshot=0, CONTROL=0, all scratch=0.
REQ-028 Reset asserted the cycle after a read SHALL suppress that read's readdatavalid.
REQ-029 Bus strobes during reset SHALL have no effect.

Verification
REQ-030 Reset release, read addr 0 then 1 -> readdatavalid one cycle after each, readdata 32'h57FA_9A28 then TIMESTAMP.
REQ-031 Force counter 48'h0000_1_FFFF_FFFF via run, read word 2 then 3 -> LO then snapshot HI=32'h1 even after LO wraps again.
REQ-032 Write CONTROL=32'h2, wait 10 cycles, read word 2 twice -> identical values; write 32'h3 -> next LO read 0.
REQ-033 Write scratch 0 = 32'hDEAD_BEEF, then byteenable=4'b0010 data 32'h0000_1200 -> read returns 32'hDEAD_12EF.
REQ-034 read+write same cycle to scratch 1, then read addr 15 -> scratch 1 unchanged, unmapped returns 0.
REQ-035 Assert reset_n low mid-read with freeze set -> no readdatavalid, CONTROL reads 0, counter counting after release.

Source files
------------

// File: rtl/sysid_info_regs.sv
// System identification block: read-only ID/timestamp words, free-running uptime
// counter with a snapshot of its upper bits, a freeze/clear control word and scratch registers.
module sysid_info_regs #(
  parameter logic [31:0] SYSTEM_ID   = 32'h57FA_9A28,
  parameter logic [31:0] TIMESTAMP   = 32'h0,
  parameter int          UPTIME_W    = 48,
  parameter int          NUM_SCRATCH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [3:0] ADDR_SYSID   = 4'd0;
  localparam logic [3:0] ADDR_TSTAMP  = 4'd1;
  localparam logic [3:0] ADDR_UP_LO   = 4'd2;
  localparam logic [3:0] ADDR_UP_HI   = 4'd3;
  localparam logic [3:0] ADDR_CONTROL = 4'd4;
  localparam int         SCRATCH_BASE = 5;

  logic [UPTIME_W-1:0] uptime_cnt;
  logic [63:0]         uptime_ext;
  logic [31:0]         uptime_hi;
  logic                freeze;
  logic [31:0]         scratch [NUM_SCRATCH];

  logic                wr_en;
  logic                ctrl_wr;
  logic                clear_req;
  logic [31:0]         rd_data;

  logic [31:0]         rdata_p0;
  logic                vld_p0;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  // A simultaneous read wins; the write half of the access is dropped.
  assign wr_en      = write & ~read;
  assign ctrl_wr    = wr_en & (address == ADDR_CONTROL);
  assign clear_req  = ctrl_wr & byteenable[0] & writedata[0];
  assign uptime_ext = 64'(uptime_cnt);

  always_comb begin
    rd_data = '0;
    case (address)
      ADDR_SYSID:   rd_data = SYSTEM_ID;
      ADDR_TSTAMP:  rd_data = TIMESTAMP;
      ADDR_UP_LO:   rd_data = uptime_ext[31:0];
      ADDR_UP_HI:   rd_data = uptime_hi;
      ADDR_CONTROL: rd_data = {30'b0, freeze, 1'b0};
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (address == 4'(SCRATCH_BASE + i)) rd_data = scratch[i];
        end
      end
    endcase
  end

  // Register state and the read-capture stage (p0)
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      uptime_cnt <= '0;
      uptime_hi  <= '0;
      freeze     <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
      rdata_p0   <= '0;
      vld_p0     <= 1'b0;
    end else begin
      if (clear_req)    uptime_cnt <= '0;
      else if (!freeze) uptime_cnt <= uptime_cnt + UPTIME_W'(1);

      if (ctrl_wr && byteenable[0]) freeze <= writedata[1];

      // HI snapshot is taken from the same pre-update count that LO returns.
      if (read && (address == ADDR_UP_LO)) uptime_hi <= uptime_ext[63:32];

      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (wr_en && (address == 4'(SCRATCH_BASE + i)))
          scratch[i] <= merge_lanes(scratch[i], writedata, byteenable);
      end

      vld_p0 <= read;
      if (read) rdata_p0 <= rd_data;
    end
  end

  // Output stage (p1): a reset in this cycle cancels a read captured in p0
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= vld_p0;
      if (vld_p0) readdata <= rdata_p0;
    end
  end

endmodule

// File: tb/tb_sysid_info_regs.sv
// Directed bench for sysid_info_regs: ID words, uptime LO/HI snapshot, freeze/clear,
// scratch byte lanes, read/write collision and reset behaviour.
module tb_sysid_info_regs;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  sysid_info_regs #(
    .SYSTEM_ID  (32'h57FA_9A28),
    .TIMESTAMP  (32'h6543_2100),
    .UPTIME_W   (48),
    .NUM_SCRATCH(2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  task automatic do_read(input logic [3:0] a, output logic [31:0] d,
                         output logic v, output logic early);
    @(negedge clock); address = a; read = 1'b1;
    @(negedge clock); read = 1'b0; early = readdatavalid;
    @(negedge clock); d = readdata; v = readdatavalid;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clock); address = a; writedata = d; byteenable = be; write = 1'b1;
    @(negedge clock); write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v, e;
    reset_n = 1'b0; read = 1'b1; write = 1'b1; address = 4'd5;
    writedata = 32'hFFFF_FFFF; byteenable = 4'hF;
    repeat (3) @(negedge clock);
    n_checks++; if (readdatavalid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", readdatavalid); end
    n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", readdata); end
    read = 1'b0; write = 1'b0; reset_n = 1'b1;
    do_read(4'd2, d, v, e);
    n_checks++; if (v !== 1'b1 || d !== 32'h1) begin n_fail++; $display("FAIL reset_uptime: got v=%b d=%h expected v=1 d=1", v, d); end
    do_read(4'd5, d, v, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_scratch: got %h expected 0", d); end
    do_read(4'd4, d, v, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_control: got %h expected 0", d); end
  endtask

  task automatic test_sysid();
    logic [31:0] d; logic v, e;
    do_read(4'd0, d, v, e);
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL sysid_early_valid: got %b expected 0", e); end
    n_checks++; if (v !== 1'b1 || d !== 32'h57FA_9A28) begin n_fail++; $display("FAIL sysid_word0: got v=%b d=%h expected v=1 d=57fa9a28", v, d); end
    @(negedge clock);
    n_checks++; if (readdatavalid !== 1'b0 || readdata !== 32'h57FA_9A28) begin n_fail++; $display("FAIL sysid_hold: got v=%b d=%h expected v=0 d=57fa9a28", readdatavalid, readdata); end
    do_read(4'd1, d, v, e);
    n_checks++; if (v !== 1'b1 || d !== 32'h6543_2100) begin n_fail++; $display("FAIL sysid_timestamp: got v=%b d=%h expected v=1 d=65432100", v, d); end
  endtask

  task automatic test_uptime_snapshot();
    logic [31:0] d; logic v, e;
    @(negedge clock);
    force dut.uptime_cnt = 48'h0001_FFFF_FFF0;
    #1 release dut.uptime_cnt;
    do_read(4'd2, d, v, e);
    n_checks++; if (d !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL uptime_lo: got %h expected fffffff1", d); end
    repeat (20) @(negedge clock);
    do_read(4'd3, d, v, e);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL uptime_hi_snapshot: got %h expected 1", d); end
    do_read(4'd2, d, v, e);
    n_checks++; if (d !== 32'h0000_000B) begin n_fail++; $display("FAIL uptime_lo_wrapped: got %h expected 0000000b", d); end
    do_read(4'd3, d, v, e);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL uptime_hi_updated: got %h expected 2", d); end
  endtask

  task automatic test_freeze_clear();
    logic [31:0] d, a_val; logic v, e;
    do_write(4'd4, 32'h2, 4'hF);
    repeat (10) @(negedge clock);
    do_read(4'd2, a_val, v, e);
    do_read(4'd2, d, v, e);
    n_checks++; if (d !== a_val) begin n_fail++; $display("FAIL freeze_hold: got %h expected %h", d, a_val); end
    do_read(4'd4, d, v, e);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL control_freeze_rb: got %h expected 2", d); end
    do_write(4'd4, 32'h3, 4'hF);
    do_read(4'd2, d, v, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL clear_frozen_lo: got %h expected 0", d); end
    do_read(4'd4, d, v, e);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL control_selfclear: got %h expected 2", d); end
    do_write(4'd4, 32'h0, 4'b1110);
    do_read(4'd4, d, v, e);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL control_byteenable: got %h expected 2", d); end
    do_write(4'd4, 32'h0, 4'b0001);
    do_read(4'd2, a_val, v, e);
    n_checks++; if (a_val !== 32'h1) begin n_fail++; $display("FAIL unfreeze_first: got %h expected 1", a_val); end
    do_read(4'd2, d, v, e);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL unfreeze_count: got %h expected 4", d); end
  endtask

  task automatic test_scratch();
    logic [31:0] d; logic v, e;
    do_write(4'd5, 32'hDEAD_BEEF, 4'hF);
    do_write(4'd5, 32'h0000_1200, 4'b0010);
    do_read(4'd5, d, v, e);
    n_checks++; if (d !== 32'hDEAD_12EF) begin n_fail++; $display("FAIL scratch_lane: got %h expected dead12ef", d); end
    do_write(4'd5, 32'hFFFF_FFFF, 4'b0000);
    do_read(4'd5, d, v, e);
    n_checks++; if (d !== 32'hDEAD_12EF) begin n_fail++; $display("FAIL scratch_be_zero: got %h expected dead12ef", d); end
  endtask

  task automatic test_back_to_back();
    @(negedge clock); address = 4'd6; writedata = 32'h1234_5678; byteenable = 4'hF; write = 1'b1;
    @(negedge clock); write = 1'b0; read = 1'b1;
    @(negedge clock); read = 1'b0;
    @(negedge clock);
    n_checks++; if (readdatavalid !== 1'b1 || readdata !== 32'h1234_5678) begin n_fail++; $display("FAIL b2b_scratch1: got v=%b d=%h expected v=1 d=12345678", readdatavalid, readdata); end
  endtask

  task automatic test_rw_conflict();
    logic [31:0] d; logic v, e;
    @(negedge clock); address = 4'd6; writedata = 32'h0; byteenable = 4'hF; read = 1'b1; write = 1'b1;
    @(negedge clock); read = 1'b0; write = 1'b0;
    @(negedge clock);
    n_checks++; if (readdatavalid !== 1'b1 || readdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rw_read_served: got v=%b d=%h expected v=1 d=12345678", readdatavalid, readdata); end
    do_read(4'd6, d, v, e);
    n_checks++; if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL rw_write_ignored: got %h expected 12345678", d); end
    do_read(4'd15, d, v, e);
    n_checks++; if (v !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL unmapped_15: got v=%b d=%h expected v=1 d=0", v, d); end
    do_read(4'd7, d, v, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_7: got %h expected 0", d); end
    do_write(4'd0, 32'h0, 4'hF);
    do_read(4'd0, d, v, e);
    n_checks++; if (d !== 32'h57FA_9A28) begin n_fail++; $display("FAIL ro_write_ignored: got %h expected 57fa9a28", d); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d, a_val; logic v, e;
    do_write(4'd4, 32'h2, 4'hF);
    @(negedge clock); address = 4'd4; read = 1'b1;
    @(negedge clock); read = 1'b0; reset_n = 1'b0;
    @(negedge clock);
    n_checks++; if (readdatavalid !== 1'b0) begin n_fail++; $display("FAIL midread_valid: got %b expected 0", readdatavalid); end
    n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL midread_data: got %h expected 0", readdata); end
    reset_n = 1'b1;
    do_read(4'd4, d, v, e);
    n_checks++; if (v !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL midread_control: got v=%b d=%h expected v=1 d=0", v, d); end
    do_read(4'd2, a_val, v, e);
    do_read(4'd2, d, v, e);
    n_checks++; if (d - a_val !== 32'd3) begin n_fail++; $display("FAIL midread_counting: got delta %0d expected 3", d - a_val); end
    do_read(4'd6, d, v, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midread_scratch: got %h expected 0", d); end
  endtask

  initial begin
    reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0;
    writedata = '0; byteenable = '0;
    test_reset();
    test_sysid();
    test_uptime_snapshot();
    test_freeze_clear();
    test_scratch();
    test_back_to_back();
    test_rw_conflict();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
